ring_arbiter: RTL

Round-robin arbiter that shares one downstream resource among N requesters. It holds a one-hot priority pointer that rotates like our ring counter. It grants one requester at a time, keeps the grant while that requester holds its request, and preempts a requester that exceeds a hold limit. It sits between the requesting masters and the shared datapath and drives that datapath's select and enable.

---
 rtl/ring_arbiter_pkg.sv | 18 +
 rtl/ring_arbiter_if.sv | 23 ++
 rtl/ring_arbiter_rr_pick.sv | 33 +++
 rtl/ring_arbiter.sv | 103 ++++++++++
 4 files changed

// File: rtl/ring_arbiter_pkg.sv
// Shared types and helpers for the round-robin ring arbiter.
package arb_pkg;

    localparam int MAX_N = 32;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    // Rotate a one-hot vector toward higher index within the low n bits, wrapping n-1 back to 0.
    function automatic logic [MAX_N-1:0] rotl1(input logic [MAX_N-1:0] v, input int n);
        logic [MAX_N-1:0] mask;
        mask = (MAX_N'(1) << n) - MAX_N'(1);
        return ((v << 1) | (v >> (n - 1))) & mask;
    endfunction

endpackage

// File: rtl/ring_arbiter_if.sv
// Requester-side bus of the ring arbiter: request vector in, one-hot grant and status out.
interface ring_arbiter_if #(
    parameter int N = 4
);
    localparam int IDW = $clog2(N);

    logic           en;
    logic [N-1:0]   req;
    logic [N-1:0]   grant;
    logic           grant_valid;
    logic [IDW-1:0] grant_id;
    logic           preempt;

    modport master (
        output en, req,
        input  grant, grant_valid, grant_id, preempt
    );

    modport slave (
        input  en, req,
        output grant, grant_valid, grant_id, preempt
    );
endinterface

// File: rtl/ring_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above the one-hot pointer, with wrap.
module rr_pick #(
    parameter  int N   = 4,
    localparam int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [N-1:0]   ptr,
    output logic [N-1:0]   winner,
    output logic [IDW-1:0] index
);

    logic [2*N-1:0] dbl_req;
    logic [2*N-1:0] mask;
    logic [2*N-1:0] masked;
    logic [2*N-1:0] first;

    // Doubling the request vector turns the wrap-around scan into a plain lowest-set-bit search.
    assign dbl_req = {req, req};
    assign mask    = ~({{N{1'b0}}, ptr} - {{(2*N-1){1'b0}}, 1'b1});
    assign masked  = dbl_req & mask;
    assign first   = masked & (~masked + {{(2*N-1){1'b0}}, 1'b1});
    assign winner  = first[N-1:0] | first[2*N-1:N];

    always_comb begin
        index = '0;
        for (int i = 0; i < N; i++) begin
            if (winner[i]) begin
                index = IDW'(i);
            end
        end
    end

endmodule

// File: rtl/ring_arbiter.sv
// Round-robin arbiter with a rotating one-hot priority pointer and a per-tenure hold limit.
module ring_arbiter
    import arb_pkg::*;
#(
    parameter int N        = 4,
    parameter int MAX_HOLD = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    ring_arbiter_if.slave     bus
);

    localparam int IDW = $clog2(N);
    localparam int HW  = $clog2(MAX_HOLD + 1);

    state_t         state_q, state_d;
    logic [N-1:0]   ptr_q, ptr_d;
    logic [N-1:0]   grant_q, grant_d;
    logic [IDW-1:0] id_q, id_d;
    logic           preempt_q, preempt_d;
    logic [HW-1:0]  hold_q, hold_d;

    logic [N-1:0]   winner;
    logic [IDW-1:0] winner_id;
    logic [N-1:0]   ptr_rot;
    logic           owner_req;

    rr_pick #(.N(N)) u_pick (
        .req    (bus.req),
        .ptr    (ptr_q),
        .winner (winner),
        .index  (winner_id)
    );

    assign ptr_rot   = N'(rotl1(MAX_N'(grant_q), N));
    assign owner_req = |(bus.req & grant_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= {1'b1, {(N-1){1'b0}}};
            grant_q   <= '0;
            id_q      <= '0;
            preempt_q <= 1'b0;
            hold_q    <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            grant_q   <= grant_d;
            id_q      <= id_d;
            preempt_q <= preempt_d;
            hold_q    <= hold_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        grant_d   = grant_q;
        id_d      = id_q;
        preempt_d = 1'b0;
        hold_d    = hold_q;

        unique case (state_q)
            IDLE: begin
                grant_d = '0;
                id_d    = '0;
                hold_d  = '0;
                if (bus.en && (|bus.req)) begin
                    state_d = OWN;
                    grant_d = winner;
                    id_d    = winner_id;
                    hold_d  = HW'(1);
                end
            end
            OWN: begin
                // A release on the timeout cycle wins over the preempt, so preempt stays low.
                if (!owner_req || (hold_q == HW'(MAX_HOLD))) begin
                    state_d   = IDLE;
                    grant_d   = '0;
                    id_d      = '0;
                    hold_d    = '0;
                    ptr_d     = ptr_rot;
                    preempt_d = owner_req;
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                id_d    = '0;
                hold_d  = '0;
            end
        endcase
    end

    assign bus.grant       = grant_q;
    assign bus.grant_valid = |grant_q;
    assign bus.grant_id    = id_q;
    assign bus.preempt     = preempt_q;

endmodule
